// File: rtl/timer_prog.sv
// Programmable interval timer: prescaler, shadow-loaded period, one-shot/periodic.
// Define TIMER_MISS_EN to add the sticky `miss` overrun flag.
module timer_prog #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   period_in,
  input  logic [PRESC_W-1:0] presc_in,
  input  logic               ack,
  output logic               pulse,
  output logic               irq,
  output logic               running,
  output logic [WIDTH-1:0]   count
`ifdef TIMER_MISS_EN
  ,
  output logic               miss
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0]   C1 = 1;
  localparam logic [PRESC_W-1:0] P1 = 1;

  state_t             state;
  logic [WIDTH-1:0]   per;
  logic [WIDTH-1:0]   sh_per;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] sh_presc;
  logic [PRESC_W-1:0] pcnt;
  logic               pend;
  logic               one_shot;
  logic               go;
  logic               tick;
  logic               expiry;

  // stop beats start; start/stop cycles never count
  always_comb begin
    go     = start && !stop;
    tick   = !stop && !start && (state == RUN) && en && (pcnt == presc);
    expiry = tick && (count >= per);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pulse    <= 1'b0;
      irq      <= 1'b0;
      running  <= 1'b0;
      count    <= '0;
      pcnt     <= '0;
      per      <= '0;
      sh_per   <= '0;
      presc    <= '0;
      sh_presc <= '0;
      pend     <= 1'b0;
      one_shot <= 1'b0;
    end else begin
      pulse <= expiry;
      if (load) begin
        sh_per   <= period_in;
        sh_presc <= presc_in;
      end
      if (stop) begin
        state   <= IDLE;
        running <= 1'b0;
        count   <= '0;
        pcnt    <= '0;
      end else if (go) begin
        state    <= RUN;
        running  <= 1'b1;
        count    <= '0;
        pcnt     <= '0;
        one_shot <= mode;
      end else if (state == RUN && en) begin
        pcnt <= tick ? '0 : pcnt + P1;
        if (expiry) begin
          count <= '0;
          if (one_shot) begin
            state   <= DONE;
            running <= 1'b0;
          end
        end else if (tick) begin
          count <= count + C1;
        end
      end
      // a pending load only takes effect on an interval boundary
      if (go || expiry) begin
        pend  <= 1'b0;
        per   <= load ? period_in : (pend ? sh_per : per);
        presc <= load ? presc_in : (pend ? sh_presc : presc);
      end else if (load) begin
        if (state == RUN) begin
          pend <= 1'b1;
        end else begin
          per   <= period_in;
          presc <= presc_in;
        end
      end
      if (expiry) begin
        irq <= 1'b1;
      end else if (ack) begin
        irq <= 1'b0;
      end
    end
  end

`ifdef TIMER_MISS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      miss <= 1'b0;
    end else if (ack) begin
      miss <= 1'b0;
    end else if (expiry && irq) begin
      miss <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/timer_prog.md
Name: timer_prog

Overview:
- Parametrised programmable interval timer; next generation of the single-channel pulse timer in the I/O subsystem of the single-cycle CPU.
- Adds a clock prescaler, a programmable period of parametrised width, and periodic or one-shot mode.
- Adds start/stop control, a shadow-loaded period, and a sticky interrupt flag with acknowledge.
- Feeds the interrupt/IO-poll logic.

Parameters:
WIDTH, 16, width of period register and main counter
PRESC_W, 8, width of prescaler register and prescaler counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: (re)start counting from zero
stop  input  1  one-cycle pulse: return to IDLE
en  input  1  count enable; low freezes both counters (pause), state held
mode  input  1  0 = periodic, 1 = one-shot; sampled on start
load  input  1  write period_in/presc_in into shadow registers
period_in  input  WIDTH  period value P
presc_in  input  PRESC_W  prescale value D
ack  input  1  clears irq
pulse  output  1  one-cycle expiry strobe
irq  output  1  sticky expiry flag
running  output  1  high in RUN state
count  output  WIDTH  current main counter value

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE; pulse=0, irq=0, running=0, count=0; prescaler counter=0.
- Reset: active period register=0, shadow period=0, active prescale=0, shadow prescale=0, pending-load flag=0.
- States:
  - IDLE: counters held at 0, pulse=0. start -> RUN.
  - RUN: counting. stop -> IDLE.
  - RUN, one-shot, expiry -> DONE.
  - DONE: counters held, running=0. start -> RUN; stop -> IDLE.
- Entering RUN on start: both counters cleared to 0; mode latched. start in RUN restarts the same way and re-latches mode.
- Prescaler (RUN and en=1 only):
  - If pcnt == D: tick=1, pcnt <= 0.
  - Else: pcnt <= pcnt+1.
  - D=0 gives a tick every enabled cycle.
- Main counter (on tick only):
  - If count < P: count <= count+1, pulse <= 0.
  - Else: pulse <= 1, count <= 0.
- Expiry interval: (P+1)*(D+1) enabled cycles. The first pulse after start comes (P+1)*(D+1) cycles after the start cycle, registered.
- Counter arithmetic: count and pcnt are exactly WIDTH and PRESC_W bits and compare unsigned against the full register width. They never exceed P/D, so no wrap-around is possible.
- pulse: registered, high exactly one cycle per expiry. Forced 0 whenever en=0, in IDLE, and in DONE.
- irq:
  - Set on the cycle pulse is set.
  - Cleared by ack.
  - Expiry and ack in the same cycle: irq stays 1 (set wins).
- load:
  - Writes the shadow registers in every state.
  - In IDLE or DONE: active registers are also updated the same cycle.
  - In RUN: pending-load flag is set. Active P and D update at the next expiry (same edge as pulse), then the flag clears. The current interval is never shortened.
  - load and start in the same cycle: new values are used for the new run.
- stop and start in the same cycle: stop wins.
- reset in the same cycle as any input: reset wins.
- en=0 for N cycles in RUN: expiry delayed by exactly N cycles; no tick or pulse lost or duplicated.
- Mid-operation reset: everything returns to reset values next cycle, including shadow registers and irq.

Optional Feature:
- Macro: TIMER_MISS_EN.
- Defined:
  - Adds output port `miss` (1 bit, reset 0).
  - miss sets when an expiry occurs while irq is already 1 and ack is not asserted that cycle.
  - miss is sticky; cleared by ack together with irq.
- Not defined: no `miss` port; no associated logic.

Test Plan:
- Reset, load P=3 D=0, start mode=0, en=1 -> pulse on cycles 4, 8, 12 after start; irq=1 from cycle 4 until ack.
- P=2 D=1, periodic -> pulse every 6 cycles; count steps 0,1,2 changing every 2 cycles.
- P=1 D=0, one-shot -> a single pulse 2 cycles after start, then state DONE with running=0 and no further pulses for 20 cycles; start again -> pulse 2 cycles later.
- P=4 D=0, en low for 3 cycles mid-interval -> pulse at cycle 8 instead of 5.
- In RUN with P=7, load P=1 at count=2 -> current pulse still at cycle 8; following pulses every 2 cycles.
- ack on the same cycle as a pulse -> irq remains 1.
- With TIMER_MISS_EN, second expiry without ack -> miss=1; ack -> irq=0 and miss=0.
- reset asserted mid-count -> all outputs 0 next cycle; no pulse afterwards without a new start.
